// File: rtl/wb_pkg.sv
// wb_pkg: load-size codes, load-queue entry type and load formatter shared by wb_merge_stage
package wb_pkg;
  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;
  localparam int WB_DW_MAX = 1024;
  localparam int WB_AW_MAX = 16;
  localparam int WB_OFF_MAX = $clog2(WB_DW_MAX / 8);
  typedef struct packed {
    logic [WB_AW_MAX-1:0] waddr;
    logic [WB_DW_MAX-1:0] wdata;
  } wb_entry_t;
  function automatic logic [WB_DW_MAX-1:0] ld_format(
    input logic [WB_DW_MAX-1:0] rdata,
    input logic [1:0] size,
    input logic sgn,
    input logic [WB_OFF_MAX-1:0] offset
  );
    logic [WB_DW_MAX-1:0] s;
    s = rdata >> {offset, 3'b000};
    return (size == LD_WORD || size == 2'd3) ? s :
           (size == LD_HALF) ? {{(WB_DW_MAX-16){sgn & s[15]}}, s[15:0]} :
           {{(WB_DW_MAX-8){sgn & s[7]}}, s[7:0]};
  endfunction
endpackage

// File: rtl/wb_load_queue.sv
// wb_load_queue: in-order FIFO of formatted loads that also reports its occupied destinations
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int AW = 4,
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  wb_entry_t       i_din,
  output wb_entry_t       o_head,
  output logic [PW:0]     o_count,
  output logic [2**AW-1:0] o_mask
);
  wb_entry_t r_mem [QDEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0] r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr <= r_wr + PW'(1);
      end
      if (i_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < QDEPTH; i++)
      if ({1'b0, PW'(i) - r_rd} < r_count) o_mask[r_mem[i].waddr[AW-1:0]] = 1'b1;
  end
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/wb_merge_stage.sv
// wb_merge_stage: merges EXE results and queued/bypassed loads onto one RF write port; WB_FWD_EN adds write forwarding
module wb_merge_stage
  import wb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int QDEPTH = 4,
  localparam int OW = $clog2(DW / 8),
  localparam int PW = $clog2(QDEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_waddr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_waddr,
  input  logic [DW-1:0]   ld_rdata,
  input  logic [1:0]      ld_size,
  input  logic            ld_signed,
  input  logic [OW-1:0]   ld_offset,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
`ifdef WB_FWD_EN
  output logic [2**AW-1:0] pend_mask,
  input  logic [AW-1:0]   fwd_raddr,
  output logic            fwd_hit,
  output logic [DW-1:0]   fwd_data
`else
  output logic [2**AW-1:0] pend_mask
`endif
);
  logic [PW:0] w_count;
  wb_entry_t w_head;
  wb_entry_t w_din;
  logic [2**AW-1:0] w_qmask;
  logic [DW-1:0] w_fmt;
  logic [DW-1:0] w_head_data;
  logic [AW-1:0] w_head_addr;
  logic w_acc;
  logic w_pop;
  logic w_bypass;
  logic w_push;
  logic r_wen;
  logic r_ld;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  wb_load_queue #(.AW(AW), .QDEPTH(QDEPTH)) u_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count),
    .o_mask  (w_qmask)
  );
  assign ld_ready = w_count < (PW+1)'(QDEPTH);
  assign w_acc = ld_valid && ld_ready;
  assign w_pop = !ex_valid && w_count != '0;
  assign w_bypass = !ex_valid && w_count == '0 && w_acc;
  assign w_push = w_acc && !w_bypass;
  assign w_fmt = DW'(ld_format(WB_DW_MAX'(ld_rdata), ld_size, ld_signed, WB_OFF_MAX'(ld_offset)));
  assign w_din = '{waddr: WB_AW_MAX'(ld_waddr), wdata: WB_DW_MAX'(w_fmt)};
  assign w_head_addr = AW'(w_head.waddr);
  assign w_head_data = DW'(w_head.wdata);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen <= 1'b0;
      r_ld <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= ex_valid || w_pop || w_bypass;
      r_ld <= !ex_valid && (w_pop || w_bypass);
      r_waddr <= ex_valid ? ex_waddr : w_pop ? w_head_addr : ld_waddr;
      r_wdata <= ex_valid ? ex_wdata : w_pop ? w_head_data : w_fmt;
    end
  end
  assign rf_wen = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign pend_mask = w_qmask | ({{(2**AW-1){1'b0}}, r_ld} << r_waddr);
`ifdef WB_FWD_EN
  assign fwd_hit = r_wen && r_waddr == fwd_raddr;
  assign fwd_data = r_wdata;
`endif
endmodule
